seq_pattern_tx: RTL
===================

Name: seq_pattern_tx

Overview:
Serial pattern transmitter. It is the generator side of the FSM sequence-detector family: it serialises a programmable bit pattern onto a 1-bit line, one bit per clock, MSB-first, with optional repeats separated by idle gaps. It drives `seq_11` and similar detectors in self-checking loopback benches, and serves as a reusable serial stimulus source in FSM designs.

Parameters:
- WIDTH, 8: maximum pattern length in bits.
- LEN_W, 4: width of the len port; must hold the value WIDTH.
- RPT_W, 4: width of the repeat_n port.
- GAP_CYCLES, 1: idle cycles inserted between repeats (0 allowed).

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: request a transmission; sampled only in IDLE.
- pattern, input, WIDTH: bits to send; the low `len` bits are sent, MSB of that field first.
- len, input, LEN_W: number of bits to send. 0 or any value > WIDTH is treated as WIDTH.
- repeat_n, input, RPT_W: number of extra repeats; total transmissions = repeat_n + 1.
- out, output, 1: serial data bit.
- out_valid, output, 1: high while `out` carries a pattern bit.
- busy, output, 1: high in every state except IDLE.
- done, output, 1: one-cycle pulse after the final bit.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transmission):
  - state = IDLE.
  - out = 0, out_valid = 0, busy = 0, done = 0.
  - Internal shift register, bit counter, repeat counter and gap counter all cleared.
- States: IDLE, SHIFT, GAP, DONE. All outputs are registered.
- IDLE:
  - out = 0, out_valid = 0.
  - On a clock edge with start = 1: latch pattern, the effective len (L) and repeat_n into internal registers; go to SHIFT.
  - Latency: the first bit appears on `out` in the cycle immediately after start was sampled.
- SHIFT:
  - out = pattern[L-1], then pattern[L-2], … down to pattern[0], one bit per cycle; out_valid = 1 throughout.
  - After bit 0:
    - repeats remaining and GAP_CYCLES > 0 → GAP.
    - repeats remaining and GAP_CYCLES = 0 → restart directly at bit L-1 (back-to-back, no idle cycle).
    - no repeats remaining → DONE.
- GAP:
  - out = 0, out_valid = 0 for exactly GAP_CYCLES cycles.
  - Decrement the repeat counter, then return to SHIFT starting at bit L-1.
- DONE:
  - done = 1 for exactly one cycle, busy = 1, out = 0; then IDLE.
- Input handling while busy:
  - start is ignored in SHIFT, GAP and DONE (no queuing).
  - Changes on pattern, len and repeat_n while busy have no effect; only the latched copies are used.
- Boundaries:
  - L = 1: a single bit per transmission.
  - repeat_n = all-ones: 2^RPT_W transmissions; the counter must not wrap early.
  - start held high continuously: a new transmission begins on the first IDLE cycle after DONE, giving one IDLE cycle between runs.
- Timing: total cycles from start to done = (repeat_n+1)·L + repeat_n·GAP_CYCLES + 1.

Decomposition:
- Shared package `seq_pkg` holds:
  - the state encoding (IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2, DONE = 2'd3);
  - the default WIDTH and GAP_CYCLES constants, shared with the detector benches.
- Optional sub-module `piso_shift`: WIDTH-bit parallel-load, MSB-first shift register with load/shift enables. All control stays in `seq_pattern_tx`.

Test Plan:
1. pattern = 8'hB6, len = 8, repeat_n = 0, start pulse at cycle 0 → out = 1,0,1,1,0,1,1,0 on cycles 1–8 with out_valid = 1; done = 1 on cycle 9 only; busy low from cycle 10.
2. pattern = 8'h05, len = 3 → out = 1,0,1 on cycles 1–3, done on cycle 4. Repeat with len = 0 and pattern = 8'hFF → eight 1s, done on cycle 9.
3. GAP_CYCLES = 2, pattern = 2'b11, len = 2, repeat_n = 1 → out = 1,1,0,0,1,1; out_valid = 1,1,0,0,1,1; done on cycle 7. With GAP_CYCLES = 0 → four consecutive 1s, done on cycle 5.
4. Start pulse at cycle 3 during a running transmission, pattern changed mid-run → the original bit stream is unchanged and no second transmission starts.
5. rst asserted asynchronously mid-SHIFT (between clock edges) → out, out_valid and busy go to 0 immediately; after release, a fresh start transmits correctly from bit L-1.
6. Loopback: out drives the in port of `seq_11` with pattern 8'b0110_1110, len = 8 → detector out asserts exactly 3 times, at the expected cycles.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence generator/detector family:
// FSM state encoding and default geometry constants.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  localparam int SEQ_WIDTH      = 8;
  localparam int SEQ_GAP_CYCLES = 1;

endpackage

// File: rtl/seq_pattern_tx_piso_shift.sv
// Parallel-load, MSB-first shift register; load takes priority over shift.
module piso_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] data,
  output logic             msb
);

  logic [WIDTH-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else if (load) begin
      sr <= data;
    end else if (shift) begin
      sr <= sr << 1;
    end
  end

  assign msb = sr[WIDTH-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends the low len bits of pattern MSB-first,
// repeat_n extra times with GAP_CYCLES idle cycles between transmissions.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int WIDTH      = SEQ_WIDTH,
  parameter int LEN_W      = 4,
  parameter int RPT_W      = 4,
  parameter int GAP_CYCLES = SEQ_GAP_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [RPT_W-1:0] repeat_n,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 2);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

  seq_state_t       state;
  logic [WIDTH-1:0] pat_reg;
  logic [LEN_W-1:0] last_idx_reg;
  logic [LEN_W-1:0] bit_cnt_reg;
  logic [RPT_W-1:0] rpt_cnt_reg;
  logic [GAP_W-1:0] gap_cnt_reg;

  logic [LEN_W-1:0] eff_len;
  logic [WIDTH-1:0] aligned;
  logic [WIDTH-1:0] reload_src;
  logic             restart;
  logic             piso_load;
  logic             piso_shift_en;
  logic             piso_msb;

  always_comb begin
    eff_len = len;
    if (len == '0 || len > LEN_W'(WIDTH)) begin
      eff_len = LEN_W'(WIDTH);
    end
  end

  // The active field is left-aligned so the shifter always emits from its MSB.
  assign aligned    = pattern << (LEN_W'(WIDTH) - eff_len);
  assign reload_src = (state == IDLE) ? aligned : pat_reg;

  assign restart = ((state == SHIFT) && (bit_cnt_reg == '0) && (rpt_cnt_reg != '0) &&
                    (GAP_CYCLES == 0)) ||
                   ((state == GAP) && (gap_cnt_reg == '0));

  // The bit on out is driven directly at load time, so the shifter holds the rest.
  assign piso_load     = ((state == IDLE) && start) || restart;
  assign piso_shift_en = (state == SHIFT) && (bit_cnt_reg != '0);

  piso_shift #(
    .WIDTH (WIDTH)
  ) u_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (piso_load),
    .shift (piso_shift_en),
    .data  (reload_src << 1),
    .msb   (piso_msb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pat_reg      <= '0;
      last_idx_reg <= '0;
      bit_cnt_reg  <= '0;
      rpt_cnt_reg  <= '0;
      gap_cnt_reg  <= '0;
      out          <= 1'b0;
      out_valid    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          out       <= 1'b0;
          out_valid <= 1'b0;
          if (start) begin
            pat_reg      <= aligned;
            last_idx_reg <= eff_len - 1'b1;
            bit_cnt_reg  <= eff_len - 1'b1;
            rpt_cnt_reg  <= repeat_n;
            out          <= aligned[WIDTH-1];
            out_valid    <= 1'b1;
            busy         <= 1'b1;
            state        <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_cnt_reg != '0) begin
            out         <= piso_msb;
            bit_cnt_reg <= bit_cnt_reg - 1'b1;
          end else if (rpt_cnt_reg == '0) begin
            out       <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end else if (GAP_CYCLES == 0) begin
            rpt_cnt_reg <= rpt_cnt_reg - 1'b1;
            out         <= pat_reg[WIDTH-1];
            bit_cnt_reg <= last_idx_reg;
          end else begin
            out         <= 1'b0;
            out_valid   <= 1'b0;
            gap_cnt_reg <= GAP_LAST;
            state       <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt_reg != '0) begin
            gap_cnt_reg <= gap_cnt_reg - 1'b1;
          end else begin
            rpt_cnt_reg <= rpt_cnt_reg - 1'b1;
            out         <= pat_reg[WIDTH-1];
            out_valid   <= 1'b1;
            bit_cnt_reg <= last_idx_reg;
            state       <= SHIFT;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
